// File: rtl/drv_pkg.sv
// Shared drive-path definitions: FSM state encoding and default duty constants.
package drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        TRACK = 2'd2,
        STOP  = 2'd3
    } drv_state_t;

    localparam int BASE_DUTY             = 16384;
    localparam int MAX_DUTY_CYCLE_OFFSET = 8250;

endpackage

// File: rtl/diff_drive_mixer_if.sv
// Control/duty bundle between the PID loop, the mixer and the two PWM channels.
interface diff_drive_mixer_if
    import drv_pkg::*;
#(
    parameter int PWM_RESOLUTION = 17
);
    logic                             clk_en;
    logic                             en;
    logic                             estop;
    logic                             mode_diff;
    logic        [PWM_RESOLUTION-1:0] base_duty;
    logic signed [PWM_RESOLUTION:0]   offset_in;
    logic        [PWM_RESOLUTION-1:0] duty_l;
    logic        [PWM_RESOLUTION-1:0] duty_r;
    logic                             at_target;
    logic                             clamp_flag;
    drv_state_t                       state;

    // Side that supplies the control words and consumes the duties.
    modport master (
        output clk_en, en, estop, mode_diff, base_duty, offset_in,
        input  duty_l, duty_r, at_target, clamp_flag, state
    );

    // Mixer side.
    modport slave (
        input  clk_en, en, estop, mode_diff, base_duty, offset_in,
        output duty_l, duty_r, at_target, clamp_flag, state
    );
endinterface

// File: rtl/slew_limiter.sv
// Moves one duty value toward its target by at most STEP per update.
module slew_limiter #(
    parameter int WIDTH = 17,
    parameter int STEP  = 512
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] next,
    output logic             reached
);
    // A step at least as large as the full range means "jump straight to target",
    // so clamping it to the largest representable gap keeps the arithmetic in WIDTH bits.
    localparam longint FULL_L = (longint'(1) << WIDTH) - 1;
    localparam longint LIM_L  = (longint'(STEP) > FULL_L) ? FULL_L : longint'(STEP);
    localparam logic [WIDTH-1:0] LIM = LIM_L[WIDTH-1:0];

    logic [WIDTH-1:0] up_gap;
    logic [WIDTH-1:0] dn_gap;

    // Choose between a full step and landing exactly on the target.
    always_comb begin
        up_gap  = target - cur;
        dn_gap  = cur - target;
        next    = cur;
        if (target > cur) begin
            next = (up_gap > LIM) ? (cur + LIM) : target;
        end else if (target < cur) begin
            next = (dn_gap > LIM) ? (cur - LIM) : target;
        end
        reached = (next == target);
    end
endmodule

// File: rtl/diff_drive_mixer.sv
// Clamps the PID offset, mixes it with the base duty into left/right targets,
// and slews the registered duties toward them under a run/stop FSM with e-stop.
module diff_drive_mixer
    import drv_pkg::*;
#(
    parameter int PWM_RESOLUTION = 17,
    parameter int DUTY_MAX       = 65536,
    parameter int MAX_OFFSET     = MAX_DUTY_CYCLE_OFFSET,
    parameter int SLEW_STEP      = 512
) (
    input  logic                clk,
    input  logic                reset_n,
    diff_drive_mixer_if.slave   bus
);
    localparam int W  = PWM_RESOLUTION;
    localparam int CW = PWM_RESOLUTION + 2;

    localparam logic signed [CW-1:0] OFF_MAX = CW'(MAX_OFFSET);
    localparam logic signed [CW-1:0] OFF_MIN = -OFF_MAX;
    localparam logic signed [CW-1:0] DMAX_S  = CW'(DUTY_MAX);
    localparam logic        [W-1:0]  DMAX_U  = W'(DUTY_MAX);

    // Symmetric clamp of the control offset.
    function automatic logic signed [CW-1:0] clamp_offset(input logic signed [CW-1:0] x);
        if (x > OFF_MAX) return OFF_MAX;
        if (x < OFF_MIN) return OFF_MIN;
        return x;
    endfunction

    // Saturate a mixed value into the legal duty range [0, DUTY_MAX].
    function automatic logic [W-1:0] sat_duty(input logic signed [CW-1:0] x);
        if (x[CW-1])    return '0;
        if (x > DMAX_S) return DMAX_U;
        return x[W-1:0];
    endfunction

    drv_state_t        state_q;
    logic [W-1:0]      duty_l_q, duty_r_q;
    logic [W-1:0]      duty_l_d, duty_r_d;
    logic              at_target_q, clamp_flag_q;

    logic signed [CW-1:0] base_ext, off_ext, off_c, l_raw, r_raw;
    logic [W-1:0]         tgt_l, tgt_r;
    logic                 clamp_hit, rch_l, rch_r, both_reached;

    // Mixing is done two bits wider than the duty so base +/- offset never wraps.
    // With en low every path leads to STOP or IDLE, so the target is simply zero.
    always_comb begin
        base_ext  = $signed({2'b00, bus.base_duty});
        off_ext   = $signed({bus.offset_in[W], bus.offset_in});
        off_c     = clamp_offset(off_ext);
        clamp_hit = (off_c != off_ext);
        l_raw     = bus.mode_diff ? (base_ext - off_c) : base_ext;
        r_raw     = base_ext + off_c;
        tgt_l     = bus.en ? sat_duty(l_raw) : '0;
        tgt_r     = bus.en ? sat_duty(r_raw) : '0;
    end

    slew_limiter #(.WIDTH(W), .STEP(SLEW_STEP)) u_slew_l (
        .cur     (duty_l_q),
        .target  (tgt_l),
        .next    (duty_l_d),
        .reached (rch_l)
    );

    slew_limiter #(.WIDTH(W), .STEP(SLEW_STEP)) u_slew_r (
        .cur     (duty_r_q),
        .target  (tgt_r),
        .next    (duty_r_d),
        .reached (rch_r)
    );

    assign both_reached = rch_l & rch_r;

    // Run/stop FSM and duty registers; e-stop overrides everything except reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            duty_l_q     <= '0;
            duty_r_q     <= '0;
            at_target_q  <= 1'b0;
            clamp_flag_q <= 1'b0;
        end else if (bus.estop) begin
            state_q      <= IDLE;
            duty_l_q     <= '0;
            duty_r_q     <= '0;
            at_target_q  <= 1'b0;
            clamp_flag_q <= 1'b0;
        end else if (bus.clk_en) begin
            duty_l_q     <= duty_l_d;
            duty_r_q     <= duty_r_d;
            at_target_q  <= both_reached;
            clamp_flag_q <= clamp_hit;
            case (state_q)
                IDLE: begin
                    if (bus.en) state_q <= RAMP;
                end
                RAMP: begin
                    if (!bus.en)           state_q <= STOP;
                    else if (both_reached) state_q <= TRACK;
                end
                TRACK: begin
                    if (!bus.en) state_q <= STOP;
                end
                STOP: begin
                    if (bus.en)            state_q <= RAMP;
                    else if (both_reached) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.duty_l     = duty_l_q;
    assign bus.duty_r     = duty_r_q;
    assign bus.at_target  = at_target_q;
    assign bus.clamp_flag = clamp_flag_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_diff_drive_mixer.sv
// Bench for diff_drive_mixer: directed scenarios plus random traffic, checked
// against an arithmetic reference model of the mixer.
module tb_diff_drive_mixer;
    localparam int RES       = 17;
    localparam int DUTY_MAX  = 65536;
    localparam int MAXO      = 8250;
    localparam int SLEW_STEP = 512;

    localparam int S_IDLE = 0, S_RAMP = 1, S_TRACK = 2, S_STOP = 3;

    logic clk;
    logic reset_n;
    bit   chk_on;
    int   n_checks, n_errors;

    diff_drive_mixer_if #(.PWM_RESOLUTION(RES)) ifc ();

    diff_drive_mixer #(
        .PWM_RESOLUTION (RES),
        .DUTY_MAX       (DUTY_MAX),
        .MAX_OFFSET     (MAXO),
        .SLEW_STEP      (SLEW_STEP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not hold.
    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state, m_l, m_r;
    bit m_at, m_clamp;

    function automatic int sat_d(input int x);
        if (x < 0) return 0;
        if (x > DUTY_MAX) return DUTY_MAX;
        return x;
    endfunction

    function automatic int slew(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > SLEW_STEP)  return cur + SLEW_STEP;
        if (d < -SLEW_STEP) return cur - SLEW_STEP;
        return tgt;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int raw, off, tl, tr, nl, nr;
        bit done;
        if (!reset_n || ifc.estop) begin
            m_state = S_IDLE; m_l = 0; m_r = 0; m_at = 0; m_clamp = 0;
        end else if (ifc.clk_en) begin
            raw = $signed(ifc.offset_in);
            off = (raw > MAXO) ? MAXO : ((raw < -MAXO) ? -MAXO : raw);
            m_clamp = (off != raw);
            if (ifc.en) begin
                tl = sat_d(ifc.mode_diff ? int'(ifc.base_duty) - off : int'(ifc.base_duty));
                tr = sat_d(int'(ifc.base_duty) + off);
            end else begin
                tl = 0; tr = 0;
            end
            nl = slew(m_l, tl);
            nr = slew(m_r, tr);
            done = (nl == tl) && (nr == tr);
            m_l = nl; m_r = nr; m_at = done;
            if (m_state == S_IDLE)       m_state = ifc.en ? S_RAMP : S_IDLE;
            else if (m_state == S_RAMP)  m_state = !ifc.en ? S_STOP : (done ? S_TRACK : S_RAMP);
            else if (m_state == S_TRACK) m_state = !ifc.en ? S_STOP : S_TRACK;
            else                         m_state = ifc.en ? S_RAMP : (done ? S_IDLE : S_STOP);
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on && reset_n) begin
            chk("duty_l",     int'(ifc.duty_l),     m_l);
            chk("duty_r",     int'(ifc.duty_r),     m_r);
            chk("state",      int'(ifc.state),      m_state);
            chk("at_target",  int'(ifc.at_target),  int'(m_at));
            chk("clamp_flag", int'(ifc.clamp_flag), int'(m_clamp));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic updates(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ifc.clk_en = 1'b1;
            @(negedge clk);
            ifc.clk_en = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic set_in(input bit en, input bit md, input int base, input int off);
        ifc.en        = en;
        ifc.mode_diff = md;
        ifc.base_duty = RES'(base);
        ifc.offset_in = (RES+1)'(off);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; chk_on = 0;
        reset_n = 1'b0;
        ifc.clk_en = 0; ifc.estop = 0;
        set_in(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_duty_l", int'(ifc.duty_l), 0);
        chk("rst_duty_r", int'(ifc.duty_r), 0);
        chk("rst_state",  int'(ifc.state), S_IDLE);
        chk("rst_at",     int'(ifc.at_target), 0);
        chk("rst_clamp",  int'(ifc.clamp_flag), 0);
        reset_n = 1'b1;
        chk_on  = 1;

        // Asynchronous reset in the middle of a ramp.
        set_in(1, 1, 16384, 0);
        updates(5, 4);
        chk("ramp_pre_rst", int'(ifc.duty_l), 5 * 512);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_duty_l", int'(ifc.duty_l), 0);
        chk("arst_duty_r", int'(ifc.duty_r), 0);
        chk("arst_state",  int'(ifc.state), S_IDLE);
        @(negedge clk);
        reset_n = 1'b1;

        // Soft start to 16384 in 512 steps.
        updates(31, 4);
        chk("ramp31_l",     int'(ifc.duty_l), 15872);
        chk("ramp31_state", int'(ifc.state), S_RAMP);
        chk("ramp31_at",    int'(ifc.at_target), 0);
        updates(1, 4);
        chk("ramp32_l",     int'(ifc.duty_l), 16384);
        chk("ramp32_r",     int'(ifc.duty_r), 16384);
        chk("ramp32_state", int'(ifc.state), S_TRACK);
        chk("ramp32_at",    int'(ifc.at_target), 1);

        // Clamped differential offset.
        set_in(1, 1, 16384, 10000);
        updates(1, 2);
        chk("clamp_flag", int'(ifc.clamp_flag), 1);
        updates(19, 2);
        chk("clamp_l",     int'(ifc.duty_l), 8134);
        chk("clamp_r",     int'(ifc.duty_r), 24634);
        chk("clamp_state", int'(ifc.state), S_TRACK);

        // Upper saturation, single-sided mode.
        set_in(1, 0, 60000, 8250);
        updates(110, 2);
        chk("sat_r",     int'(ifc.duty_r), 65536);
        chk("sat_l",     int'(ifc.duty_l), 60000);
        chk("sat_clamp", int'(ifc.clamp_flag), 0);

        // Soft stop and re-acquire.
        set_in(1, 1, 16384, 0);
        updates(110, 2);
        chk("back_l",     int'(ifc.duty_l), 16384);
        chk("back_state", int'(ifc.state), S_TRACK);
        ifc.en = 0;
        updates(10, 2);
        chk("stop10_l",     int'(ifc.duty_l), 11264);
        chk("stop10_state", int'(ifc.state), S_STOP);
        ifc.en = 1;
        updates(1, 2);
        chk("reacq_l",     int'(ifc.duty_l), 11776);
        chk("reacq_state", int'(ifc.state), S_RAMP);
        updates(20, 2);
        chk("reacq_track", int'(ifc.state), S_TRACK);
        ifc.en = 0;
        updates(32, 2);
        chk("stop32_state", int'(ifc.state), S_IDLE);
        chk("stop32_r",     int'(ifc.duty_r), 0);
        ifc.en = 1;
        updates(40, 2);
        chk("track2_state", int'(ifc.state), S_TRACK);

        // E-stop between strobes.
        ifc.estop = 1;
        @(negedge clk);
        chk("estop_l",     int'(ifc.duty_l), 0);
        chk("estop_r",     int'(ifc.duty_r), 0);
        chk("estop_state", int'(ifc.state), S_IDLE);
        updates(3, 2);
        chk("estop_hold_state", int'(ifc.state), S_IDLE);
        chk("estop_hold_l",     int'(ifc.duty_l), 0);
        ifc.estop = 0;
        updates(2, 2);
        chk("post_estop_l", int'(ifc.duty_l), 1024);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ifc.clk_en = ($urandom_range(0, 2) == 0);
            ifc.estop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) ifc.en = ~ifc.en;
            if ($urandom_range(0, 19) == 0) ifc.mode_diff = ~ifc.mode_diff;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0: ifc.base_duty = RES'($urandom_range(0, 131071));
                    1: ifc.base_duty = RES'($urandom_range(60000, 65536));
                    2: ifc.base_duty = RES'($urandom_range(0, 9000));
                    default: ifc.base_duty = RES'(16384);
                endcase
            end
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) ifc.offset_in = (RES+1)'($urandom);
                else ifc.offset_in = (RES+1)'($urandom_range(0, 2 * 9000) - 9000);
            end
            @(negedge clk);
        end
        ifc.clk_en = 0;
        ifc.estop  = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
